// File: rtl/ms_io_mailbox.sv
// IO-bus mailbox: CPU DATA writes feed a TX stream FIFO, DATA reads drain an RX stream FIFO.
// Reads take two cycles (busy, then data); writes complete in the access cycle.
module ms_io_mailbox #(
    parameter logic [15:0] CAddrBase  = 16'h0040,
    parameter int unsigned CDepthLog2 = 4
) (
    input  logic        AClkH,
    input  logic        AResetH,
    input  logic        AClkHEn,
    input  logic [15:0] AIoAddr,
    input  logic [63:0] AIoMosi,
    input  logic [3:0]  AIoWrSize,
    input  logic [3:0]  AIoRdSize,
    output logic [63:0] AIoMiso,
    output logic        AIoBusy,
    output logic [31:0] ATxData,
    output logic        ATxValid,
    input  logic        ATxReady,
    input  logic [31:0] ARxData,
    input  logic        ARxValid,
    output logic        ARxReady,
    output logic        AIrq
);

    localparam int unsigned Depth = 1 << CDepthLog2;
    localparam int unsigned CntW  = CDepthLog2 + 1;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StRdWait = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [1:0]            rd_off_q, rd_off_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  rd_empty_q, rd_empty_d;

    logic [31:0]           tx_mem_q [Depth];
    logic [CDepthLog2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [31:0]           rx_mem_q [Depth];
    logic [CDepthLog2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;

    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_udf_q, rx_udf_d;
    logic                  irq_rx_en_q, irq_rx_en_d;
    logic                  irq_txe_en_q, irq_txe_en_d;

    logic [15:0]           addr_off;
    logic [1:0]            off;
    logic                  hit, wr_hit, rd_start;
    logic                  tx_full, rx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop, flush;
    logic [31:0]           rx_head, rd_value;
    logic                  unused_bits;

    assign addr_off    = AIoAddr - CAddrBase;
    assign off         = addr_off[1:0];
    assign hit         = (AIoAddr >= CAddrBase) && (AIoAddr <= CAddrBase + 16'd3);
    assign wr_hit      = hit && (AIoWrSize != 4'h0);
    assign rd_start    = (state_q == StIdle) && hit && (AIoRdSize != 4'h0) && (AIoWrSize == 4'h0);
    assign unused_bits = ^{AIoMosi[63:32], addr_off[15:2]};

    assign tx_full  = (tx_cnt_q == CntW'(Depth));
    assign rx_full  = (rx_cnt_q == CntW'(Depth));
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_push = wr_hit && (off == 2'd0) && !tx_full;
    assign tx_pop  = ATxValid && ATxReady;
    assign rx_push = ARxValid && ARxReady;
    // The pop only happens if the capture cycle saw data; an empty capture is an underflow.
    assign rx_pop  = (state_q == StRdWait) && (rd_off_q == 2'd0) && !rd_empty_q && !rx_empty;
    assign flush   = wr_hit && (off == 2'd2) && AIoMosi[2];

    assign rx_head = rx_empty ? 32'h0 : rx_mem_q[rx_rd_ptr_q];

    always_comb begin
        rd_value = '0;
        case (off)
            2'd0: rd_value = rx_head;
            2'd1: rd_value = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                              rx_udf_q, tx_ovf_q, rx_empty, tx_full};
            2'd2: rd_value = {30'h0, irq_txe_en_q, irq_rx_en_q};
            default: rd_value = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rd_off_d     = rd_off_q;
        rd_data_d    = rd_data_q;
        rd_empty_d   = rd_empty_q;
        tx_ovf_d     = tx_ovf_q;
        rx_udf_d     = rx_udf_q;
        irq_rx_en_d  = irq_rx_en_q;
        irq_txe_en_d = irq_txe_en_q;

        if (state_q == StIdle) begin
            if (rd_start) begin
                state_d    = StRdWait;
                rd_off_d   = off;
                rd_data_d  = rd_value;
                rd_empty_d = (off == 2'd0) && rx_empty;
            end
        end else begin
            state_d = StIdle;
        end

        if (wr_hit && (off == 2'd1)) begin
            if (AIoMosi[2]) tx_ovf_d = 1'b0;
            if (AIoMosi[3]) rx_udf_d = 1'b0;
        end
        if (wr_hit && (off == 2'd2)) begin
            irq_rx_en_d  = AIoMosi[0];
            irq_txe_en_d = AIoMosi[1];
        end
        // New error events are applied after the clear so they win over W1C.
        if (wr_hit && (off == 2'd0) && tx_full) tx_ovf_d = 1'b1;
        if ((state_q == StRdWait) && (rd_off_q == 2'd0) && rd_empty_q) rx_udf_d = 1'b1;
    end

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + CDepthLog2'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + CDepthLog2'(tx_pop);
        tx_cnt_d    = tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + CDepthLog2'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + CDepthLog2'(rx_pop);
        rx_cnt_d    = rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
        if (flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_cnt_d    = '0;
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_cnt_d    = '0;
        end
    end

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state_q      <= StIdle;
            rd_off_q     <= '0;
            rd_data_q    <= '0;
            rd_empty_q   <= 1'b0;
            tx_wr_ptr_q  <= '0;
            tx_rd_ptr_q  <= '0;
            tx_cnt_q     <= '0;
            rx_wr_ptr_q  <= '0;
            rx_rd_ptr_q  <= '0;
            rx_cnt_q     <= '0;
            tx_ovf_q     <= 1'b0;
            rx_udf_q     <= 1'b0;
            irq_rx_en_q  <= 1'b0;
            irq_txe_en_q <= 1'b0;
        end else if (AClkHEn) begin
            state_q      <= state_d;
            rd_off_q     <= rd_off_d;
            rd_data_q    <= rd_data_d;
            rd_empty_q   <= rd_empty_d;
            tx_wr_ptr_q  <= tx_wr_ptr_d;
            tx_rd_ptr_q  <= tx_rd_ptr_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wr_ptr_q  <= rx_wr_ptr_d;
            rx_rd_ptr_q  <= rx_rd_ptr_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_ovf_q     <= tx_ovf_d;
            rx_udf_q     <= rx_udf_d;
            irq_rx_en_q  <= irq_rx_en_d;
            irq_txe_en_q <= irq_txe_en_d;
        end
    end

    always_ff @(posedge AClkH) begin
        if (!AResetH && AClkHEn) begin
            if (tx_push) tx_mem_q[tx_wr_ptr_q] <= AIoMosi[31:0];
            if (rx_push && !flush) rx_mem_q[rx_wr_ptr_q] <= ARxData;
        end
    end

    assign AIoBusy  = rd_start;
    assign AIoMiso  = (state_q == StRdWait) ? {32'h0, rd_data_q} : '0;
    assign ATxValid = (tx_cnt_q != '0);
    assign ATxData  = tx_mem_q[tx_rd_ptr_q];
    assign ARxReady = !rx_full;
    assign AIrq     = (irq_rx_en_q && !rx_empty) || (irq_txe_en_q && (tx_cnt_q == '0));

endmodule

// File: tb/tb_ms_io_mailbox.sv
// Directed plus randomized bench for ms_io_mailbox against a queue-based mailbox model.
module tb_ms_io_mailbox;

    localparam logic [15:0] BASE = 16'h0040;

    logic        AClkH = 1'b0;
    logic        AResetH, AClkHEn;
    logic [15:0] AIoAddr;
    logic [63:0] AIoMosi, AIoMiso;
    logic [3:0]  AIoWrSize, AIoRdSize;
    logic        AIoBusy;
    logic [31:0] ATxData, ARxData;
    logic        ATxValid, ATxReady, ARxValid, ARxReady, AIrq;

    ms_io_mailbox #(.CAddrBase(BASE), .CDepthLog2(4)) dut (
        .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
        .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoWrSize(AIoWrSize), .AIoRdSize(AIoRdSize),
        .AIoMiso(AIoMiso), .AIoBusy(AIoBusy),
        .ATxData(ATxData), .ATxValid(ATxValid), .ATxReady(ATxReady),
        .ARxData(ARxData), .ARxValid(ARxValid), .ARxReady(ARxReady), .AIrq(AIrq)
    );

    always #5 AClkH = ~AClkH;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        m_tx_ovf, m_rx_udf;
    logic [1:0]  m_ctrl;

    bit          cur_wr, commit, commit_empty;
    logic [1:0]  cur_off;
    logic [31:0] cur_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [15:0] a);
        return (a >= BASE) && (a <= BASE + 16'd3);
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] o);
        case (o)
            2'd0: return (rx_q.size() == 0) ? 32'h0 : rx_q[0];
            2'd1: return {8'h0, 8'(rx_q.size()), 8'(tx_q.size()), 4'h0, m_rx_udf, m_tx_ovf,
                          1'(rx_q.size() == 0), 1'(tx_q.size() == 16)};
            2'd2: return {30'h0, m_ctrl};
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_irq();
        return (m_ctrl[0] && rx_q.size() != 0) || (m_ctrl[1] && tx_q.size() == 0);
    endfunction

    // Check the stream side, then advance the model across one rising edge.
    task automatic cycle();
        bit tpop, rpush, tpush, flush;
        chk("tx_valid", ATxValid, 64'(tx_q.size() != 0));
        if (tx_q.size() != 0) chk("tx_data", ATxData, tx_q[0]);
        chk("rx_ready", ARxReady, 64'(rx_q.size() < 16));
        chk("irq", AIrq, 64'(model_irq()));
        if (AResetH) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_ovf = 1'b0;
            m_rx_udf = 1'b0;
            m_ctrl   = 2'b00;
        end else if (AClkHEn) begin
            tpop  = (tx_q.size() != 0) && ATxReady;
            rpush = ARxValid && (rx_q.size() < 16);
            tpush = 1'b0;
            flush = 1'b0;
            if (cur_wr) begin
                case (cur_off)
                    2'd0: if (tx_q.size() == 16) m_tx_ovf = 1'b1; else tpush = 1'b1;
                    2'd1: begin
                        if (cur_data[2]) m_tx_ovf = 1'b0;
                        if (cur_data[3]) m_rx_udf = 1'b0;
                    end
                    2'd2: begin
                        m_ctrl = cur_data[1:0];
                        flush  = cur_data[2];
                    end
                    default: ;
                endcase
            end
            if (commit && commit_empty) m_rx_udf = 1'b1;
            if (flush) begin
                tx_q.delete();
                rx_q.delete();
            end else begin
                if (tpop) void'(tx_q.pop_front());
                if (tpush) tx_q.push_back(cur_data);
                if (commit && !commit_empty) void'(rx_q.pop_front());
                if (rpush) rx_q.push_back(ARxData);
            end
        end
        @(posedge AClkH);
        @(negedge AClkH);
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [31:0] data, input bit rd_also);
        AIoAddr   = addr;
        AIoMosi   = {$urandom, data};
        AIoWrSize = 4'h4;
        AIoRdSize = rd_also ? 4'h4 : 4'h0;
        #1;
        chk("wr_busy", AIoBusy, 64'h0);
        chk("wr_miso", AIoMiso, 64'h0);
        cur_wr   = in_range(addr);
        cur_off  = 2'(addr - BASE);
        cur_data = data;
        cycle();
        cur_wr    = 1'b0;
        AIoWrSize = 4'h0;
        AIoRdSize = 4'h0;
    endtask

    task automatic io_read(input logic [15:0] addr, output logic [31:0] got);
        logic [31:0] exp;
        logic [1:0]  o;
        AIoAddr   = addr;
        AIoWrSize = 4'h0;
        AIoRdSize = 4'h8;
        #1;
        got = 32'h0;
        if (!in_range(addr)) begin
            chk("rd_miss_busy", AIoBusy, 64'h0);
            chk("rd_miss_miso", AIoMiso, 64'h0);
            cycle();
            AIoRdSize = 4'h0;
            return;
        end
        o   = 2'(addr - BASE);
        exp = model_read(o);
        chk("rd_busy1", AIoBusy, 64'h1);
        chk("rd_miso1", AIoMiso, 64'h0);
        commit_empty = (o == 2'd0) && (rx_q.size() == 0);
        cycle();
        chk("rd_busy2", AIoBusy, 64'h0);
        chk("rd_data", AIoMiso, {32'h0, exp});
        got    = AIoMiso[31:0];
        commit = (o == 2'd0);
        cycle();
        commit    = 1'b0;
        AIoRdSize = 4'h0;
        #1;
        chk("rd_idle_miso", AIoMiso, 64'h0);
        chk("rd_idle_busy", AIoBusy, 64'h0);
    endtask

    task automatic rx_push_words(input int n);
        for (int i = 0; i < n; i++) begin
            ARxValid = 1'b1;
            ARxData  = $urandom;
            cycle();
        end
        ARxValid = 1'b0;
    endtask

    initial begin
        logic [31:0] got, exp, d;
        int          op;

        AResetH = 1'b1; AClkHEn = 1'b1; AIoAddr = '0; AIoMosi = '0;
        AIoWrSize = '0; AIoRdSize = '0; ATxReady = 1'b0; ARxValid = 1'b0; ARxData = '0;
        cur_wr = 0; commit = 0; commit_empty = 0; cur_off = '0; cur_data = '0;
        m_tx_ovf = 0; m_rx_udf = 0; m_ctrl = '0;
        repeat (2) begin
            @(posedge AClkH);
            @(negedge AClkH);
        end
        AResetH = 1'b0;
        chk("rst_miso", AIoMiso, 64'h0);
        chk("rst_busy", AIoBusy, 64'h0);
        chk("rst_txvalid", ATxValid, 64'h0);
        chk("rst_rxready", ARxReady, 64'h1);
        chk("rst_irq", AIrq, 64'h0);
        io_read(BASE + 16'd1, got);
        chk("rst_stat", got, 64'h2);

        // TX path with an immediately ready consumer
        ATxReady = 1'b1;
        io_write(BASE, 32'hDEADBEEF, 1'b0);
        chk("tx1_valid", ATxValid, 64'h1);
        chk("tx1_data", ATxData, 64'hDEADBEEF);
        cycle();
        chk("tx1_popped", ATxValid, 64'h0);
        ATxReady = 1'b0;

        // RX path: three words in, three CPU reads out
        rx_push_words(3);
        io_read(BASE + 16'd1, got);
        chk("rx3_cnt", got[23:16], 64'd3);
        for (int i = 0; i < 3; i++) io_read(BASE, got);
        io_read(BASE + 16'd1, got);
        chk("rx0_cnt", got[23:16], 64'd0);

        // TX overflow and W1C
        for (int i = 0; i < 17; i++) io_write(BASE, $urandom, 1'b0);
        io_read(BASE + 16'd1, got);
        chk("ovf_txcnt", got[15:8], 64'd16);
        chk("ovf_full", got[0], 64'h1);
        chk("ovf_flag", got[2], 64'h1);
        io_write(BASE + 16'd1, 32'h4, 1'b0);
        io_read(BASE + 16'd1, got);
        chk("ovf_clr", got[2], 64'h0);
        io_write(BASE + 16'd2, 32'h4, 1'b0);
        chk("flush_tx", ATxValid, 64'h0);

        // RX underflow
        io_read(BASE, got);
        chk("udf_data", got, 64'h0);
        io_read(BASE + 16'd1, got);
        chk("udf_flag", got[3], 64'h1);
        chk("udf_cnt", got[23:16], 64'h0);
        io_write(BASE + 16'd1, 32'h8, 1'b0);

        // Interrupt sources
        io_write(BASE + 16'd2, 32'h1, 1'b0);
        rx_push_words(1);
        chk("irq_rx_on", AIrq, 64'h1);
        io_read(BASE, got);
        chk("irq_rx_off", AIrq, 64'h0);
        io_write(BASE + 16'd2, 32'h2, 1'b0);
        chk("irq_txe_on", AIrq, 64'h1);
        io_write(BASE + 16'd2, 32'h0, 1'b0);

        // Stream push concurrent with CPU pop, flush concurrent with push, write+read together
        rx_push_words(2);
        ARxValid = 1'b1;
        ARxData  = $urandom;
        io_read(BASE, got);
        ARxValid = 1'b0;
        io_read(BASE + 16'd1, got);
        ARxValid = 1'b1;
        io_write(BASE + 16'd2, 32'h4, 1'b0);
        ARxValid = 1'b0;
        io_read(BASE + 16'd1, got);
        chk("flush_rxcnt", got[23:16], 64'h0);
        io_write(BASE, $urandom, 1'b1);
        io_read(BASE + 16'd1, got);

        // Clock enable low while the read data is being presented
        rx_push_words(1);
        AIoAddr = BASE; AIoRdSize = 4'h8;
        #1;
        exp = model_read(2'd0);
        commit_empty = 1'b0;
        chk("frz_busy1", AIoBusy, 64'h1);
        cycle();
        AClkHEn = 1'b0; ARxValid = 1'b1; ARxData = $urandom;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_busy", AIoBusy, 64'h0);
            chk("frz_miso", AIoMiso, {32'h0, exp});
            cycle();
        end
        AClkHEn = 1'b1; ARxValid = 1'b0;
        #1;
        chk("frz_miso_end", AIoMiso, {32'h0, exp});
        commit = 1'b1;
        cycle();
        commit = 1'b0; AIoRdSize = 4'h0;
        io_read(BASE + 16'd1, got);

        // Reset during the data cycle of a read
        rx_push_words(2);
        AIoAddr = BASE; AIoRdSize = 4'h8;
        #1;
        chk("rstrd_busy1", AIoBusy, 64'h1);
        cycle();
        AResetH = 1'b1;
        cycle();
        AResetH = 1'b0; AIoRdSize = 4'h0;
        #1;
        chk("rstrd_miso", AIoMiso, 64'h0);
        chk("rstrd_busy", AIoBusy, 64'h0);
        io_read(BASE + 16'd1, got);
        chk("rstrd_stat", got, 64'h2);

        // Randomized mix of CPU accesses and stream traffic
        for (int i = 0; i < 400; i++) begin
            ATxReady = 1'($urandom_range(0, 1));
            ARxValid = 1'($urandom_range(0, 1));
            ARxData  = $urandom;
            op = $urandom_range(0, 9);
            case (op)
                0, 1: io_write(BASE, $urandom, 1'b0);
                2, 3: io_read(BASE, got);
                4: io_read(BASE + 16'd1, got);
                5: begin
                    d = $urandom;
                    d[2] = ($urandom_range(0, 7) == 0);
                    io_write(BASE + 16'd2, d, 1'($urandom_range(0, 1)));
                end
                6: io_write(BASE + 16'd1, $urandom, 1'b0);
                7: cycle();
                8: if ($urandom_range(0, 1) != 0) io_read(BASE + 16'd2 + 16'($urandom_range(1, 3)), got);
                   else io_write(BASE - 16'd1, $urandom, 1'b0);
                default: io_read(BASE + 16'd3, got);
            endcase
        end
        ATxReady = 1'b0;
        ARxValid = 1'b0;
        io_read(BASE + 16'd1, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
